// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed active-low segment bus, debounces each
// digit strobe, decodes digits into BCD slots and presents complete four-digit frames on a
// valid/ready interface. A frame that completes while the previous one is still unconsumed
// is dropped and flagged in a sticky overrun bit.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,      // active-high synchronous reset
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam logic [7:0] L_STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {StCollect, StPresent} state_t;

    logic [6:0]              r_seg, r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_sel, r_sel_prev;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_slot;
    logic [NUM_DIGITS-1:0]   r_mark, r_err;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic                    r_frame_err, r_overrun;
    state_t                  r_state;

    logic                    w_same, w_onehot, w_accept, w_full, w_bad;
    logic [7:0]              w_cnt_next;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_accept_mask;

    // Stability tracking on the registered sample pair.
    always_comb begin
        w_same = (r_seg == r_seg_prev) && (r_sel == r_sel_prev);
        if (!w_same) begin
            w_cnt_next = 8'd1;
        end else if (r_cnt == L_STABLE) begin
            w_cnt_next = L_STABLE;
        end else begin
            w_cnt_next = r_cnt + 8'd1;
        end
        w_onehot      = (r_sel != '0) && ((r_sel & (r_sel - 1'b1)) == '0);
        // Accept only on the transition into the stable count, never while saturated.
        w_accept      = w_same && (r_cnt == L_STABLE - 8'd1) && w_onehot;
        w_accept_mask = w_accept ? r_sel : '0;
        w_full        = &r_mark;
    end

    // Active-low segment pattern to BCD; anything unrecognised is 4'hF and flagged.
    always_comb begin
        w_bad = 1'b0;
        unique case (r_seg)
            7'b1000000: w_nib = 4'd0;
            7'b1111001: w_nib = 4'd1;
            7'b0100100: w_nib = 4'd2;
            7'b0110000: w_nib = 4'd3;
            7'b0011001: w_nib = 4'd4;
            7'b0010010: w_nib = 4'd5;
            7'b0000010: w_nib = 4'd6;
            7'b1111000: w_nib = 4'd7;
            7'b0000000: w_nib = 4'd8;
            7'b0011000: w_nib = 4'd9;
            default: begin
                w_nib = 4'hF;
                w_bad = 1'b1;
            end
        endcase
    end

    // Input sampling and stability counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_seg      <= '0;
            r_sel      <= '0;
            r_seg_prev <= '0;
            r_sel_prev <= '0;
            r_cnt      <= '0;
        end else begin
            r_seg      <= seg_in;
            r_sel      <= dig_sel;
            r_seg_prev <= r_seg;
            r_sel_prev <= r_sel;
            r_cnt      <= w_cnt_next;
        end
    end

    // Slot collection and COLLECT/PRESENT frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_slot      <= '0;
            r_mark      <= '0;
            r_err       <= '0;
            r_bcd       <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_state     <= StCollect;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept_mask[i]) begin
                    r_slot[4*i +: 4] <= w_nib;
                end
            end
            // A completed frame releases its marks; a same-cycle acceptance still lands.
            r_mark <= (w_full ? '0 : r_mark) | w_accept_mask;
            r_err  <= ((w_full ? '0 : r_err) & ~w_accept_mask) |
                      (w_bad ? w_accept_mask : '0);

            unique case (r_state)
                StCollect: begin
                    if (w_full) begin
                        r_bcd       <= r_slot;
                        r_frame_err <= |r_err;
                        r_state     <= StPresent;
                    end
                end
                StPresent: begin
                    if (w_full) begin
                        if (out_ready) begin
                            r_bcd       <= r_slot;
                            r_frame_err <= |r_err;
                        end else begin
                            // Consumer still holds the old frame: drop the new one.
                            r_overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        r_state <= StCollect;
                    end
                end
                default: r_state <= StCollect;
            endcase
        end
    end

    assign bcd_out   = r_bcd;
    assign out_valid = (r_state == StPresent);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized digit streams,
// with a digit-run reference model feeding an expected-frame queue drained by a monitor.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overrun;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES(STABLE),
        .NUM_DIGITS   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .dig_sel  (dig_sel),
        .bcd_out  (bcd_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int frames_seen = 0;
    logic [16:0] exp_q[$];

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Reference model state: digit slots, current input run, consumer bookkeeping.
    logic [3:0]  m_nib [4];
    logic [3:0]  m_err;
    logic [3:0]  m_mark;
    logic        m_has_last;
    logic [3:0]  m_last_sel;
    logic [6:0]  m_last_seg;
    int          m_run;
    logic        m_ready_mode;
    logic        m_pending;
    logic        m_overrun;
    logic [15:0] m_bcd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++) begin
            if (s == pat[k]) return {1'b0, 4'(k)};
        end
        return 5'h1F;
    endfunction

    task automatic model_reset();
        m_mark = '0;
        m_err = '0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        m_has_last = 1'b0;
        m_last_sel = '0;
        m_last_seg = '0;
        m_run = 0;
        m_pending = 1'b0;
        m_overrun = 1'b0;
        m_bcd = '0;
    endtask

    task automatic model_complete();
        logic [16:0] f;
        f = {|m_err, m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        if (m_pending && !m_ready_mode) begin
            m_overrun = 1'b1;
        end else begin
            exp_q.push_back(f);
            m_bcd = f[15:0];
            if (!m_ready_mode) m_pending = 1'b1;
        end
        m_mark = '0;
        m_err = '0;
    endtask

    // Present (sel, seg) for n clock edges and update the model with the run it forms.
    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        int old_run;
        int idx;
        logic [4:0] d;
        old_run = (m_has_last && sel == m_last_sel && seg == m_last_seg) ? m_run : 0;
        m_run = old_run + n;
        m_has_last = 1'b1;
        m_last_sel = sel;
        m_last_seg = seg;
        if (old_run < STABLE && m_run >= STABLE && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            d = ref_decode(seg);
            m_nib[idx] = d[3:0];
            m_err[idx] = d[4];
            m_mark[idx] = 1'b1;
            if (&m_mark) model_complete();
        end
        seg_in = seg;
        dig_sel = sel;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] e_bcd,
                                 input logic e_valid, input logic e_ferr, input logic e_ovr);
        check({tag, "_bcd"}, bcd_out, e_bcd);
        check({tag, "_valid"}, out_valid, e_valid);
        check({tag, "_ferr"}, frame_err, e_ferr);
        check({tag, "_overrun"}, overrun, e_ovr);
    endtask

    // Monitor: every accepted handshake must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got bcd %0h err %0b, expected no frame",
                         bcd_out, frame_err);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("frame_bcd", bcd_out, e[15:0]);
                check("frame_err", frame_err, e[16]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic [3:0] rs;
        logic [6:0] rg;
        rst_n = 1'b1;
        seg_in = 7'h7F;
        dig_sel = '0;
        out_ready = 1'b1;
        m_ready_mode = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        check_outputs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Basic frame 4321.
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, pat[2], 6);
        drive(4'b0100, pat[3], 6);
        drive(4'b1000, pat[4], 6);
        drive(4'b0000, 7'h7F, 4);
        check("basic_one_frame", frames_seen, 1);
        check("basic_bcd_hold", bcd_out, m_bcd);

        // Short digit 2 must not be accepted until re-presented long enough.
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, pat[2], 3);
        drive(4'b0100, pat[3], 6);
        drive(4'b1000, pat[4], 6);
        drive(4'b0000, 7'h7F, 6);
        check("short_no_frame", frames_seen, 1);
        drive(4'b0010, pat[2], 6);
        drive(4'b0000, 7'h7F, 6);
        check("short_frame_after_retry", frames_seen, 2);

        // Blank digit produces 789F with error.
        drive(4'b0001, 7'h7F, 6);
        drive(4'b0010, pat[9], 6);
        drive(4'b0100, pat[8], 6);
        drive(4'b1000, pat[7], 6);
        drive(4'b0000, 7'h7F, 6);
        check("blank_frame_seen", frames_seen, 3);
        check("blank_ferr_hold", frame_err, 1'b1);

        // Reset after three accepted digits discards the partial frame.
        drive(4'b0001, pat[5], 6);
        drive(4'b0010, pat[6], 6);
        drive(4'b0100, pat[7], 6);
        pulse_reset();
        check_outputs("midreset", 16'h0000, 1'b0, 1'b0, 1'b0);
        f0 = frames_seen;
        drive(4'b1000, pat[8], 6);
        drive(4'b0000, 7'h7F, 6);
        check("midreset_needs_all", frames_seen, f0);
        drive(4'b0001, pat[5], 6);
        drive(4'b0010, pat[6], 6);
        drive(4'b0100, pat[7], 6);
        drive(4'b0000, 7'h7F, 6);
        check("midreset_refill", frames_seen, f0 + 1);

        // Non-one-hot strobe held stable changes nothing.
        drive(4'b0011, pat[3], 10);
        drive(4'b0000, 7'h7F, 4);
        check_outputs("multihot", m_bcd, 1'b0, 1'b0, 1'b0);
        check("multihot_no_frame", frames_seen, f0 + 1);

        // Randomized digit stream with an always-ready consumer.
        for (int it = 0; it < 60; it++) begin
            rs = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3))
                                            : 4'($urandom_range(0, 15));
            rg = ($urandom_range(0, 3) != 0) ? pat[$urandom_range(0, 9)]
                                             : 7'($urandom_range(0, 127));
            drive(rs, rg, $urandom_range(2, 7));
        end
        drive(4'b0000, 7'h7F, 8);
        check("random_drained", exp_q.size(), 0);

        // Overrun: consumer stalls across two complete frames.
        pulse_reset();
        m_ready_mode = 1'b0;
        out_ready = 1'b0;
        drive(4'b0001, pat[1], 6);
        drive(4'b0010, pat[1], 6);
        drive(4'b0100, pat[1], 6);
        drive(4'b1000, pat[1], 6);
        drive(4'b0000, 7'h7F, 4);
        drive(4'b0001, pat[2], 6);
        drive(4'b0010, pat[2], 6);
        drive(4'b0100, pat[2], 6);
        drive(4'b1000, pat[2], 6);
        drive(4'b0000, 7'h7F, 6);
        check_outputs("overrun", m_bcd, 1'b1, 1'b0, m_overrun);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        m_pending = 1'b0;
        check("overrun_valid_drop", out_valid, 1'b0);
        check("overrun_sticky", overrun, 1'b1);
        out_ready = 1'b1;
        m_ready_mode = 1'b1;
        drive(4'b0000, 7'h7F, 6);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical clock samples required before a digit is accepted (range 2..255).
REQ-002 Parameter: NUM_DIGITS, default 4, count of multiplexed digit positions (fixed at 4 for this block).
REQ-003 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-high reset; despite the name, 1 = reset.
REQ-005 Port: seg_in  input  7  active-low segment bus; bit6=g ... bit0=a.
REQ-006 Port: dig_sel  input  4  active-high one-hot digit strobe; bit i = digit i.
REQ-007 Port: bcd_out  output  16  decoded frame; bcd_out[4i+3:4i] = digit i.
REQ-008 Port: out_valid  output  1  frame available on bcd_out.
REQ-009 Port: out_ready  input  1  consumer accepts the frame when high together with out_valid.
REQ-010 Port: frame_err  output  1  at least one digit in the presented frame was unrecognised; qualified by out_valid.
REQ-011 Port: overrun  output  1  sticky; a completed frame was discarded because out_valid was pending.

Function
REQ-012 The block SHALL decode active-low patterns as follows: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9.
REQ-013 Any other pattern, including blank 1111111, SHALL decode to 4'hF and mark the digit erroneous.
REQ-014 The block SHALL register seg_in and dig_sel once before comparison; stability is judged on the registered pair.
REQ-015 A stability counter SHALL increment, saturating at STABLE_CYCLES, while the registered pair equals the previous registered pair; on any difference it SHALL reload to 1.
REQ-016 A digit SHALL be accepted exactly once, in the cycle the counter transitions to STABLE_CYCLES; holding the inputs longer SHALL NOT re-accept it.
REQ-017 A dig_sel that is zero or not one-hot SHALL never cause an acceptance, regardless of stability.
REQ-018 On acceptance, the decoded nibble SHALL be written to slot i, slot-mark bit i set, and slot-error bit i set or cleared per REQ-013; a re-accepted digit i before frame completion overwrites its slot.
REQ-019 The FSM SHALL have states COLLECT (out_valid=0) and PRESENT (out_valid=1).
REQ-020 When all four slot marks are set, the block SHALL in the next cycle copy the slots to bcd_out, set frame_err to the OR of the slot-error bits, clear all marks and error bits, and, from COLLECT, move to PRESENT.
REQ-021 Collection of the next frame SHALL continue while in PRESENT; bcd_out and frame_err SHALL stay constant while in PRESENT.
REQ-022 A PRESENT cycle with out_ready=1 SHALL return the FSM to COLLECT on the next edge, unless a frame completes in that same cycle; in that case the new frame is loaded and the FSM stays in PRESENT.
REQ-023 A frame completing in PRESENT with out_ready=0 SHALL be discarded, its marks cleared, and overrun set; bcd_out SHALL be unchanged.
REQ-024 Latency: inputs first presented at cycle t are accepted at cycle t+STABLE_CYCLES; out_valid rises one cycle after the fourth acceptance.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 While rst_n=1 at a clock edge, the block SHALL set: out_valid=0, bcd_out=16'h0000, frame_err=0, overrun=0, FSM=COLLECT, all slot marks, errors and data = 0, stability counter = 0, sample registers = 0.
REQ-027 Reset asserted mid-frame or in PRESENT SHALL discard all partial and pending data; the first acceptance after reset needs a full STABLE_CYCLES window.

Verification
REQ-028 The bench SHALL apply digits 1,2,3,4 on dig_sel 0001,0010,0100,1000, each held 6 cycles, with out_ready=1 -> one out_valid pulse with bcd_out=16'h4321, frame_err=0.
REQ-029 The bench SHALL hold digit 2 for only 3 cycles (STABLE_CYCLES=4) between valid digits -> no acceptance of digit 2 and no frame until digit 2 is re-presented for at least 4 cycles.
REQ-030 The bench SHALL present 1111111 on digit 0 and 9,8,7 on digits 1..3 -> bcd_out=16'h789F, frame_err=1.
REQ-031 The bench SHALL hold out_ready=0 through two complete frames (16'h1111, then 16'h2222) -> bcd_out stays 16'h1111, overrun=1; out_ready=1 for one cycle then drops out_valid.
REQ-032 The bench SHALL assert rst_n for one cycle after three of four digits are accepted -> all outputs zero; the frame then needs all four digits again.
REQ-033 The bench SHALL drive dig_sel=0011 stable for 10 cycles -> no acceptance and no change to any output.
